// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction classes, ALU op classes,
// branch kinds and the ID/EX latch payload.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_W      = 16;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_BLT   = 6'b000110;
  localparam logic [OPCODE_W-1:0] OP_BGT   = 6'b000111;
  localparam logic [OPCODE_W-1:0] OP_BLE   = 6'b010100;
  localparam logic [OPCODE_W-1:0] OP_BGE   = 6'b010101;

  typedef enum logic [2:0] {
    TYPE_R      = 3'd0,
    TYPE_I      = 3'd1,
    TYPE_LOAD   = 3'd2,
    TYPE_STORE  = 3'd3,
    TYPE_BRANCH = 3'd4
  } instr_type_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_BRANCH = 3'd1,
    ALU_RTYPE  = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_SLT    = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GT   = 3'd4,
    BR_LE   = 3'd5,
    BR_GE   = 3'd6
  } branch_kind_e;

  typedef struct packed {
    logic         legal;
    instr_type_e  itype;
    alu_op_e      alu_op;
    branch_kind_e branch_kind;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         zero_ext;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0]     read_data_1;
    logic [DATA_W-1:0]     read_data_2;
    logic [DATA_W-1:0]     immediate;
    logic [FUNCT_W-1:0]    funct;
    alu_op_e               alu_op;
    instr_type_e           itype;
    logic                  alu_src;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    branch_kind_e          branch_kind;
    logic                  illegal;
  } id_ex_t;

  // Opcode to control-field table; anything not listed comes back with legal=0.
  function automatic ctrl_t decode_opcode(input logic [OPCODE_W-1:0] opcode);
    ctrl_t c;
    c       = '0;
    c.legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin c.itype = TYPE_R;    c.alu_op = ALU_RTYPE; c.reg_write = 1'b1; end
      OP_ADDI:  begin c.itype = TYPE_I;    c.alu_op = ALU_ADD;   c.reg_write = 1'b1; end
      OP_SLTI:  begin c.itype = TYPE_I;    c.alu_op = ALU_SLT;   c.reg_write = 1'b1; end
      OP_ANDI:  begin c.itype = TYPE_I;    c.alu_op = ALU_AND;   c.reg_write = 1'b1; c.zero_ext = 1'b1; end
      OP_ORI:   begin c.itype = TYPE_I;    c.alu_op = ALU_OR;    c.reg_write = 1'b1; c.zero_ext = 1'b1; end
      OP_LW:    begin c.itype = TYPE_LOAD; c.alu_op = ALU_ADD;   c.reg_write = 1'b1; c.mem_read = 1'b1; end
      OP_SW:    begin c.itype = TYPE_STORE; c.alu_op = ALU_ADD;  c.mem_write = 1'b1; end
      OP_BEQ:   begin c.itype = TYPE_BRANCH; c.alu_op = ALU_BRANCH; c.branch_kind = BR_EQ; end
      OP_BNE:   begin c.itype = TYPE_BRANCH; c.alu_op = ALU_BRANCH; c.branch_kind = BR_NE; end
      OP_BLT:   begin c.itype = TYPE_BRANCH; c.alu_op = ALU_BRANCH; c.branch_kind = BR_LT; end
      OP_BGT:   begin c.itype = TYPE_BRANCH; c.alu_op = ALU_BRANCH; c.branch_kind = BR_GT; end
      OP_BLE:   begin c.itype = TYPE_BRANCH; c.alu_op = ALU_BRANCH; c.branch_kind = BR_LE; end
      OP_BGE:   begin c.itype = TYPE_BRANCH; c.alu_op = ALU_BRANCH; c.branch_kind = BR_GE; end
      default:  c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, $0 hardwired to zero.
module register_file
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [REG_ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [REG_ADDR_W-1:0] read_addr_1,
  input  logic [REG_ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0]     read_data_1_c,
  output logic [DATA_W-1:0]     read_data_2_c
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[REG_ADDR_W'(i)] <= '0;
      end
    end else if (write_en && (write_addr != '0)) begin
      regs[write_addr] <= write_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    if (addr == '0) begin
      return '0;
    end else if (write_en && (write_addr == addr)) begin
      return write_data;
    end
    return regs[addr];
  endfunction

  always_comb begin
    read_data_1_c = read_port(read_addr_1);
    read_data_2_c = read_port(read_addr_2);
  end

endmodule

// File: rtl/decode_module.sv
// ID stage: instruction decode, load-use hazard detection and the ID/EX latch.
// The instruction-class output is named instr_type because "type" is a reserved word.
module decode_module
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic        flush,
  input  logic        wb_write_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dest,
  output logic [31:0] alu_read_data_1,
  output logic [31:0] alu_read_data_2,
  output logic [31:0] immediate,
  output logic [5:0]  funct,
  output logic [2:0]  alu_op,
  output logic [2:0]  instr_type,
  output logic        alu_src,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  branch_kind,
  output logic        illegal,
  output logic        stall
);

  logic [OPCODE_W-1:0]   opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [IMM_W-1:0]      imm16;
  logic [DATA_W-1:0]     rf_data_1_c;
  logic [DATA_W-1:0]     rf_data_2_c;
  logic [REG_ADDR_W-1:0] dest_c;
  logic                  uses_rt_c;
  logic                  hazard_c;
  ctrl_t                 ctrl_c;
  id_ex_t                id_ex_d;
  id_ex_t                id_ex_q;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign imm16  = instruction[15:0];

  register_file u_register_file (
    .clk           (clk),
    .rst           (rst),
    .write_en      (wb_write_en),
    .write_addr    (wb_addr),
    .write_data    (wb_data),
    .read_addr_1   (rs),
    .read_addr_2   (rt),
    .read_data_1_c (rf_data_1_c),
    .read_data_2_c (rf_data_2_c)
  );

  always_comb begin
    ctrl_c    = decode_opcode(opcode);
    dest_c    = (ctrl_c.itype == TYPE_R) ? rd : rt;
    uses_rt_c = ctrl_c.legal && ((ctrl_c.itype == TYPE_R) || (ctrl_c.itype == TYPE_STORE) ||
                                 (ctrl_c.itype == TYPE_BRANCH));
    hazard_c  = ex_mem_read && (ex_dest != '0) &&
                ((ex_dest == rs) || (uses_rt_c && (ex_dest == rt)));
  end

  // A flushed or empty slot never asks fetch to hold.
  assign stall = instr_valid && !flush && hazard_c;

  always_comb begin
    id_ex_d = '0;
    if (instr_valid && !flush && !stall) begin
      if (!ctrl_c.legal) begin
        id_ex_d.illegal = 1'b1;
      end else begin
        id_ex_d.read_data_1 = rf_data_1_c;
        id_ex_d.read_data_2 = rf_data_2_c;
        id_ex_d.immediate   = ctrl_c.zero_ext ? {{(DATA_W-IMM_W){1'b0}}, imm16}
                                              : {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
        id_ex_d.funct       = instruction[5:0];
        id_ex_d.alu_op      = ctrl_c.alu_op;
        id_ex_d.itype       = ctrl_c.itype;
        id_ex_d.alu_src     = (ctrl_c.itype == TYPE_I) || (ctrl_c.itype == TYPE_LOAD) ||
                              (ctrl_c.itype == TYPE_STORE);
        id_ex_d.dest        = dest_c;
        id_ex_d.reg_write   = ctrl_c.reg_write && (dest_c != '0);
        id_ex_d.mem_read    = ctrl_c.mem_read;
        id_ex_d.mem_write   = ctrl_c.mem_write;
        id_ex_d.branch_kind = ctrl_c.branch_kind;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign alu_read_data_1 = id_ex_q.read_data_1;
  assign alu_read_data_2 = id_ex_q.read_data_2;
  assign immediate       = id_ex_q.immediate;
  assign funct           = id_ex_q.funct;
  assign alu_op          = id_ex_q.alu_op;
  assign instr_type      = id_ex_q.itype;
  assign alu_src         = id_ex_q.alu_src;
  assign dest            = id_ex_q.dest;
  assign reg_write       = id_ex_q.reg_write;
  assign mem_read        = id_ex_q.mem_read;
  assign mem_write       = id_ex_q.mem_write;
  assign branch_kind     = id_ex_q.branch_kind;
  assign illegal         = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_module.sv
// Bench for decode_module: directed scenarios followed by random traffic, all
// compared against an opcode-table reference model with its own register array.
module tb_decode_module;

  logic        clk = 1'b0;
  logic        rst, instr_valid, flush, wb_write_en, ex_mem_read;
  logic [31:0] instruction, wb_data;
  logic [4:0]  wb_addr, ex_dest;
  logic [31:0] alu_read_data_1, alu_read_data_2, immediate;
  logic [5:0]  funct;
  logic [2:0]  alu_op, instr_type, branch_kind;
  logic        alu_src, reg_write, mem_read, mem_write, illegal, stall;
  logic [4:0]  dest;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_regs [32];

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [5:0]  fn;
    logic [2:0]  aop, typ, bk;
    logic        asrc;
    logic [4:0]  dst;
    logic        rw, mr, mw, ill, stl, bubble;
  } exp_t;

  decode_module dut (
    .clk             (clk),
    .rst             (rst),
    .instruction     (instruction),
    .instr_valid     (instr_valid),
    .flush           (flush),
    .wb_write_en     (wb_write_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .ex_mem_read     (ex_mem_read),
    .ex_dest         (ex_dest),
    .alu_read_data_1 (alu_read_data_1),
    .alu_read_data_2 (alu_read_data_2),
    .immediate       (immediate),
    .funct           (funct),
    .alu_op          (alu_op),
    .instr_type      (instr_type),
    .alu_src         (alu_src),
    .dest            (dest),
    .reg_write       (reg_write),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .branch_kind     (branch_kind),
    .illegal         (illegal),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_write_en && wb_addr == idx) return wb_data;
    return ref_regs[idx];
  endfunction

  // Expected stall and ID/EX contents for the inputs currently driven.
  function automatic exp_t ref_model();
    exp_t e;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    bit legal, zext, uses_rt, hz, s, slot_live;
    e = '0; legal = 1; zext = 0;
    op = instruction[31:26]; rs = instruction[25:21];
    rt = instruction[20:16]; rd = instruction[15:11];
    case (op)
      6'h00: begin e.typ = 0; e.aop = 2; e.rw = 1; end
      6'h08: begin e.typ = 1; e.aop = 0; e.rw = 1; end
      6'h0A: begin e.typ = 1; e.aop = 5; e.rw = 1; end
      6'h0C: begin e.typ = 1; e.aop = 3; e.rw = 1; zext = 1; end
      6'h0D: begin e.typ = 1; e.aop = 4; e.rw = 1; zext = 1; end
      6'h23: begin e.typ = 2; e.aop = 0; e.rw = 1; e.mr = 1; end
      6'h2B: begin e.typ = 3; e.aop = 0; e.mw = 1; end
      6'h04: begin e.typ = 4; e.aop = 1; e.bk = 1; end
      6'h05: begin e.typ = 4; e.aop = 1; e.bk = 2; end
      6'h06: begin e.typ = 4; e.aop = 1; e.bk = 3; end
      6'h07: begin e.typ = 4; e.aop = 1; e.bk = 4; end
      6'h14: begin e.typ = 4; e.aop = 1; e.bk = 5; end
      6'h15: begin e.typ = 4; e.aop = 1; e.bk = 6; end
      default: legal = 0;
    endcase
    uses_rt = legal && (e.typ == 0 || e.typ == 3 || e.typ == 4);
    hz = ex_mem_read && ex_dest != 0 && (ex_dest == rs || (uses_rt && ex_dest == rt));
    s = instr_valid && !flush && hz;
    slot_live = !rst && instr_valid && !flush && !s;
    if (!slot_live || !legal) begin
      e = '0;
      e.stl = s;
      e.ill = slot_live && !legal;
      e.bubble = 1;
      return e;
    end
    e.stl  = 0;
    e.rd1  = ref_read(rs);
    e.rd2  = ref_read(rt);
    e.imm  = zext ? {16'h0, instruction[15:0]} : {{16{instruction[15]}}, instruction[15:0]};
    e.fn   = instruction[5:0];
    e.asrc = (e.typ >= 1 && e.typ <= 3);
    e.dst  = (e.typ == 0) ? rd : rt;
    e.rw   = e.rw && (e.dst != 0);
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e, input bit full);
    if (full || !e.bubble) begin
      check({tag, "_rd1"},   alu_read_data_1, e.rd1);
      check({tag, "_rd2"},   alu_read_data_2, e.rd2);
      check({tag, "_imm"},   immediate, e.imm);
      check({tag, "_funct"}, 32'(funct), 32'(e.fn));
    end
    check({tag, "_alu_op"},  32'(alu_op), 32'(e.aop));
    check({tag, "_type"},    32'(instr_type), 32'(e.typ));
    check({tag, "_alu_src"}, 32'(alu_src), 32'(e.asrc));
    check({tag, "_dest"},    32'(dest), 32'(e.dst));
    check({tag, "_rw"},      32'(reg_write), 32'(e.rw));
    check({tag, "_mr"},      32'(mem_read), 32'(e.mr));
    check({tag, "_mw"},      32'(mem_write), 32'(e.mw));
    check({tag, "_bk"},      32'(branch_kind), 32'(e.bk));
    check({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic cycle(input string tag);
    exp_t e;
    bit full;
    #1;
    e = ref_model();
    full = rst;
    check({tag, "_stall"}, 32'(stall), 32'(e.stl));
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    end else if (wb_write_en && wb_addr != 5'd0) begin
      ref_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    check_out(tag, e, full);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; instr_valid = 0; flush = 0; instruction = 32'd0;
    wb_write_en = 0; wb_addr = 5'd0; wb_data = 32'd0;
    ex_mem_read = 0; ex_dest = 5'd0;
  endtask

  logic [5:0] op_table [14] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B,
                                6'h04, 6'h05, 6'h06, 6'h07, 6'h14, 6'h15, 6'h3F};

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    idle();
    rst = 1;
    @(negedge clk);
    cycle("reset");

    idle(); instr_valid = 1; instruction = 32'h2001FFFB;
    cycle("addi");
    check("addi_rd1_const", alu_read_data_1, 32'd0);
    check("addi_imm_const", immediate, 32'hFFFFFFFB);
    check("addi_type_const", 32'(instr_type), 32'd1);
    check("addi_dest_const", 32'(dest), 32'd1);
    check("addi_rw_const", 32'(reg_write), 32'd1);

    idle(); instr_valid = 1; instruction = 32'h00632020;
    wb_write_en = 1; wb_addr = 5'd3; wb_data = 32'h12345678;
    cycle("bypass");
    check("bypass_rd1_const", alu_read_data_1, 32'h12345678);
    check("bypass_rd2_const", alu_read_data_2, 32'h12345678);

    idle(); instr_valid = 1; instruction = 32'h00A23020; ex_mem_read = 1; ex_dest = 5'd5;
    #1 check("loaduse_stall_const", 32'(stall), 32'd1);
    cycle("loaduse");
    check("loaduse_bubble_rw", 32'(reg_write), 32'd0);
    idle(); instr_valid = 1; instruction = 32'h00A23020;
    cycle("loaduse_next");
    check("loaduse_next_dest", 32'(dest), 32'd6);

    idle(); wb_write_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    instr_valid = 1; instruction = 32'h00000825;
    cycle("r0_same");
    idle(); instr_valid = 1; instruction = 32'h00000825;
    cycle("r0_or");
    check("r0_rd1_const", alu_read_data_1, 32'd0);
    idle(); instr_valid = 1; instruction = 32'h34018000;
    cycle("ori");
    check("ori_imm_const", immediate, 32'h00008000);

    idle(); instr_valid = 1; flush = 1; instruction = 32'h00A23020;
    ex_mem_read = 1; ex_dest = 5'd5;
    #1 check("flush_stall_const", 32'(stall), 32'd0);
    cycle("flush");

    idle(); instr_valid = 1; instruction = 32'hFC000000;
    cycle("illegal");
    check("illegal_const", 32'(illegal), 32'd1);
    idle(); instr_valid = 1; instruction = 32'h2001FFFB;
    cycle("illegal_next");
    check("illegal_next_const", 32'(illegal), 32'd0);

    idle(); instr_valid = 1; instruction = 32'h18220003;
    cycle("blt");
    check("blt_bk_const", 32'(branch_kind), 32'd3);

    idle(); instr_valid = 1; instruction = 32'h00000000;
    cycle("sll0");

    idle(); rst = 1; instr_valid = 1; instruction = 32'h00A23020;
    ex_mem_read = 1; ex_dest = 5'd5;
    cycle("rst_mid_stall");
    idle(); instr_valid = 1; instruction = 32'h00A23020;
    cycle("rst_after");

    for (int n = 0; n < 400; n++) begin
      idle();
      rst         = ($urandom_range(0, 49) == 0);
      instr_valid = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 9) == 0);
      instruction = {op_table[$urandom_range(0, 13)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
      if ($urandom_range(0, 3) == 0) instruction[15] = 1'b1;
      wb_write_en = $urandom_range(0, 1) == 1;
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_dest     = 5'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_module.md
DECODE_MODULE -- requirements
Module: decode_module

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have the following input ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- instruction  in  32  IF/ID instruction word
- instr_valid  in  1  instruction is live; 0 means treat as bubble
- flush  in  1  squash the instruction in decode (taken branch)
- wb_write_en  in  1  register-file write strobe
- wb_addr  in  5  write-back register index
- wb_data  in  32  write-back data
- ex_mem_read  in  1  instruction now in EX is a load
- ex_dest  in  5  destination index of the instruction in EX
REQ-003 The block SHALL have the following output ports, all registered as the ID/EX latch:
- alu_read_data_1  out  32  rs operand
- alu_read_data_2  out  32  rt operand
- immediate  out  32  extended imm16; bits [10:6] carry shamt for R-type
- funct  out  6  instruction[5:0]
- alu_op  out  3  ALU operation class
- type  out  3  instruction class
- alu_src  out  1  1 selects immediate as the second ALU input
- dest  out  5  rd for R-type, rt for I-type
- reg_write, mem_read, mem_write  out  1 each  downstream controls
- branch_kind  out  3  0 none, 1 beq, 2 bne, 3 blt, 4 bgt, 5 ble, 6 bge
- illegal  out  1  unknown opcode was decoded
REQ-004 The block SHALL drive stall (out, 1 bit) combinationally as a hold request to the fetch stage and IF/ID.

Function
REQ-005 The decoder SHALL map opcodes to control fields as follows:
- 000000 R-type: type 0, alu_op 2, reg_write 1
- addi 001000: type 1, alu_op 0
- slti 001010: type 1, alu_op 5
- andi 001100: type 1, alu_op 3
- ori 001101: type 1, alu_op 4
- lw 100011: type 2, alu_op 0, mem_read 1, reg_write 1
- sw 101011: type 3, alu_op 0, mem_write 1
- beq 000100, bne 000101, blt 000110, bgt 000111, ble 010100, bge 010101: type 4, alu_op 1
REQ-006 alu_src SHALL be 1 for types 1, 2 and 3, and 0 otherwise.
REQ-007 For I-type instructions, reg_write SHALL be 1 for type 1.
REQ-008 Immediate extension SHALL be zero-extension for andi and ori, and sign-extension of instruction[15:0] for all other opcodes.
REQ-009 The register file SHALL contain 32 registers of 32 bits, written on the clk edge when wb_write_en=1.
REQ-010 Writes to index 0 SHALL be ignored, and register 0 SHALL always read 0.
REQ-011 When wb_write_en=1 and wb_addr equals a nonzero source index in the same cycle, the operand read SHALL return wb_data (write-through bypass).
REQ-012 Latency: an instruction presented in cycle N SHALL appear on the ID/EX outputs after the clk edge ending cycle N.
REQ-013 Load-use hazard: stall SHALL be 1 when ex_mem_read=1, ex_dest≠0 and ex_dest equals rs, or equals rt for types 0, 3 and 4.
REQ-014 When stall=1 the latch SHALL load a bubble (all control outputs 0, dest 0).
REQ-015 A bubble SHALL be loaded when flush=1, when instr_valid=0, or when stall=1.
REQ-016 flush SHALL override stall: a flushed instruction never raises stall.
REQ-017 An unknown opcode SHALL load a bubble with illegal=1 for one cycle.
REQ-018 The all-zero instruction word (sll $0) SHALL decode as a legal R-type with dest 0, and reg_write SHALL be forced to 0 whenever dest=0.

Reset
REQ-019 A reset applied mid-stall SHALL complete in one cycle and leave stall deasserted unless the inputs still match REQ-013.
REQ-020 With rst=1 at a clk edge, every ID/EX output SHALL become 0 and all 32 registers SHALL clear to 0.
REQ-021 rst SHALL take priority over write-back and over the latch update.

Structure
REQ-022 Opcode constants, type codes, alu_op codes and branch_kind codes SHALL live in a shared package (mips_pkg) that is also used by alu_control.
REQ-023 The register file SHALL be a single sub-module, register_file, with two read ports and one write port, including the bypass and the $0 rule.
REQ-024 Decode, hazard detection and the ID/EX latch SHALL stay in decode_module.

Verification
REQ-025 Reset, then addi $1,$0,-5 (0x2001FFFB) → alu_read_data_1=0, immediate=0xFFFFFFFB, alu_src=1, type=1, dest=1, reg_write=1.
REQ-026 Write-back $3=0x12345678 in the same cycle as add $4,$3,$3 is decoded → both operands read 0x12345678.
REQ-027 ex_mem_read=1 with ex_dest=5, then decode of add $6,$5,$2 → stall=1 and a bubble is latched; the next cycle (no hazard) the add is latched normally.
REQ-028 Write-back to $0 with 0xFFFFFFFF, then decode of or $1,$0,$0 → operands read 0; ori 0x3401_8000 → immediate=0x00008000.
REQ-029 flush=1 together with a hazard → stall=0 and a bubble is latched; opcode 111111 → illegal=1 for exactly one cycle.
REQ-030 blt opcode 000110 → type=4, alu_op=1, branch_kind=3, alu_src=0, reg_write=0.
